alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage_if.sv | 59 +++++
 rtl/alu_issue_stage.sv | 101 ++++++++++
 tb/tb_alu_issue_stage.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Boundary bundle of the ALU issue stage: decode handshake, squash, bypass sources and ALU side.
// The master modport is the issue stage itself; slave is the surrounding pipeline.
interface alu_issue_stage_if;
    logic        id_valid;
    logic        id_ready;
    logic [3:0]  id_op;
    logic [1:0]  id_rs1;
    logic [1:0]  id_rs2;
    logic [15:0] id_rs1_data;
    logic [15:0] id_rs2_data;
    logic        id_use_rs2;
    logic [15:0] id_imm;
    logic [1:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;

    logic        flush;

    logic        exm_valid;
    logic        exm_reg_write;
    logic        exm_mem_read;
    logic [1:0]  exm_rd;
    logic [15:0] exm_result;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [1:0]  wb_rd;
    logic [15:0] wb_data;

    logic        ex_ready;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [1:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;

    modport master (
        input  id_valid, id_op, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
               id_use_rs2, id_imm, id_rd, id_reg_write, id_mem_read,
               flush,
               exm_valid, exm_reg_write, exm_mem_read, exm_rd, exm_result,
               wb_valid, wb_reg_write, wb_rd, wb_data,
               ex_ready,
        output id_ready,
               ex_valid, ex_op, ex_a, ex_b, ex_rd, ex_reg_write, ex_mem_read
    );

    modport slave (
        output id_valid, id_op, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
               id_use_rs2, id_imm, id_rd, id_reg_write, id_mem_read,
               flush,
               exm_valid, exm_reg_write, exm_mem_read, exm_rd, exm_result,
               wb_valid, wb_reg_write, wb_rd, wb_data,
               ex_ready,
        input  id_ready,
               ex_valid, ex_op, ex_a, ex_b, ex_rd, ex_reg_write, ex_mem_read
    );
endinterface

// File: rtl/alu_issue_stage.sv
// One-entry issue buffer between decode and the ALU with operand bypass and load-use stall.
// Define ALU_ISSUE_FORWARD_EN to bypass from EX/MEM; otherwise any EX/MEM match stalls.
module alu_issue_stage (
    input  logic               clk,
    input  logic               reset,
    alu_issue_stage_if.master  bus
);

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic [1:0]  rs1_q, rs2_q, rd_q;
    logic        use_rs2_q, reg_write_q, mem_read_q;
    logic [15:0] a_q, b_q;

    logic        full;
    logic        exm_hit1, exm_hit2, wb_hit1, wb_hit2;
    logic        hazard, issue, advance, capture;
    logic [15:0] fwd_a, fwd_b;

    assign full = (state_q == HOLD);

    always_comb begin
        exm_hit1 = full && bus.exm_valid && bus.exm_reg_write && (bus.exm_rd == rs1_q);
        exm_hit2 = full && bus.exm_valid && bus.exm_reg_write && use_rs2_q && (bus.exm_rd == rs2_q);
        wb_hit1  = full && bus.wb_valid && bus.wb_reg_write && (bus.wb_rd == rs1_q);
        wb_hit2  = full && bus.wb_valid && bus.wb_reg_write && use_rs2_q && (bus.wb_rd == rs2_q);
    end

`ifdef ALU_ISSUE_FORWARD_EN
    // EX/MEM is younger than WB, so it takes priority; a load there has no data yet.
    always_comb begin
        fwd_a  = wb_hit1 ? bus.wb_data : a_q;
        fwd_b  = wb_hit2 ? bus.wb_data : b_q;
        if (exm_hit1) fwd_a = bus.exm_result;
        if (exm_hit2) fwd_b = bus.exm_result;
        hazard = (exm_hit1 || exm_hit2) && bus.exm_mem_read;
    end
`else
    // Without the EX/MEM bypass only the register-file write-through remains.
    always_comb begin
        fwd_a  = wb_hit1 ? bus.wb_data : a_q;
        fwd_b  = wb_hit2 ? bus.wb_data : b_q;
        hazard = exm_hit1 || exm_hit2;
    end
`endif

    assign issue            = full && !hazard;
    assign advance          = issue && bus.ex_ready;
    assign capture          = bus.id_valid && bus.id_ready;
    assign bus.id_ready     = !bus.flush && (!full || advance);
    assign bus.ex_valid     = issue;
    assign bus.ex_op        = op_q;
    assign bus.ex_a         = fwd_a;
    assign bus.ex_b         = fwd_b;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_reg_write = issue && reg_write_q;
    assign bus.ex_mem_read  = issue && mem_read_q;

    always_comb begin
        state_d = state_q;
        if (bus.flush)    state_d = EMPTY;
        else if (capture) state_d = HOLD;
        else if (advance) state_d = EMPTY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // A stalled entry re-latches its bypassed operands so they outlive the producer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q        <= 4'b0000;
            rs1_q       <= 2'd0;
            rs2_q       <= 2'd0;
            rd_q        <= 2'd0;
            use_rs2_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
        end else if (capture) begin
            op_q        <= bus.id_op;
            rs1_q       <= bus.id_rs1;
            rs2_q       <= bus.id_rs2;
            rd_q        <= bus.id_rd;
            use_rs2_q   <= bus.id_use_rs2;
            reg_write_q <= bus.id_reg_write;
            mem_read_q  <= bus.id_mem_read;
            a_q         <= bus.id_rs1_data;
            b_q         <= bus.id_use_rs2 ? bus.id_rs2_data : bus.id_imm;
        end else if (full && !advance && !bus.flush) begin
            a_q         <= fwd_a;
            b_q         <= fwd_b;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected issues are queued at drive time
// and compared when the ALU side accepts them.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic reset;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic [1:0]  rd;
    } issue_t;

    issue_t sbQueue[$];
    issue_t expIssue;
    int     totalCount = 0;
    int     badCount   = 0;
    int     issueCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [1:0] rs1, input logic [15:0] d1,
                                 input logic [1:0] rs2, input logic [15:0] d2, input logic useRs2,
                                 input logic [15:0] imm, input logic [1:0] rd,
                                 input logic regWrite, input logic memRead);
        bus.id_valid     = 1'b1;
        bus.id_op        = op;
        bus.id_rs1       = rs1;
        bus.id_rs1_data  = d1;
        bus.id_rs2       = rs2;
        bus.id_rs2_data  = d2;
        bus.id_use_rs2   = useRs2;
        bus.id_imm       = imm;
        bus.id_rd        = rd;
        bus.id_reg_write = regWrite;
        bus.id_mem_read  = memRead;
    endtask

    task automatic idle();
        bus.id_valid = 1'b0;
    endtask

    task automatic setExm(input logic v, input logic rw, input logic mr, input logic [1:0] rd, input logic [15:0] res);
        bus.exm_valid     = v;
        bus.exm_reg_write = rw;
        bus.exm_mem_read  = mr;
        bus.exm_rd        = rd;
        bus.exm_result    = res;
    endtask

    task automatic setWb(input logic v, input logic rw, input logic [1:0] rd, input logic [15:0] data);
        bus.wb_valid     = v;
        bus.wb_reg_write = rw;
        bus.wb_rd        = rd;
        bus.wb_data      = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every accepted issue must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && bus.ex_valid && bus.ex_ready) begin
            issueCount++;
            if (sbQueue.size() == 0) begin
                checkOutput("sb_unexpected_issue", 32'd1, 32'd0);
            end else begin
                expIssue = sbQueue.pop_front();
                checkOutput("sb_a",  {16'h0, bus.ex_a},  {16'h0, expIssue.a});
                checkOutput("sb_b",  {16'h0, bus.ex_b},  {16'h0, expIssue.b});
                checkOutput("sb_op", {28'h0, bus.ex_op}, {28'h0, expIssue.op});
                checkOutput("sb_rd", {30'h0, bus.ex_rd}, {30'h0, expIssue.rd});
            end
        end
    end

    initial begin
        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b0;
        applyStimulus(4'h0, 2'd0, 16'h0, 2'd0, 16'h0, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
        idle();
        setExm(1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        setWb(1'b0, 1'b0, 2'd0, 16'h0);
        #2;
        checkOutput("rst_ex_valid", {31'h0, bus.ex_valid}, 32'd0);
        checkOutput("rst_ex_op",    {28'h0, bus.ex_op},    32'd0);
        checkOutput("rst_id_ready", {31'h0, bus.id_ready}, 32'd1);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Back-to-back captures, one issue per cycle
        bus.ex_ready = 1'b1;
        applyStimulus(4'h0, 2'd1, 16'h0005, 2'd0, 16'h0000, 1'b0, 16'h0003, 2'd3, 1'b1, 1'b0);
        sbQueue.push_back('{a: 16'h0005, b: 16'h0003, op: 4'h0, rd: 2'd3});
        #1 checkOutput("cap_id_ready", {31'h0, bus.id_ready}, 32'd1);
        tick();
        applyStimulus(4'h1, 2'd2, 16'h0010, 2'd3, 16'h0020, 1'b1, 16'hFFFF, 2'd1, 1'b1, 1'b0);
        sbQueue.push_back('{a: 16'h0010, b: 16'h0020, op: 4'h1, rd: 2'd1});
        #1;
        checkOutput("iss_valid",     {31'h0, bus.ex_valid},     32'd1);
        checkOutput("iss_a",         {16'h0, bus.ex_a},         32'h0005);
        checkOutput("iss_b",         {16'h0, bus.ex_b},         32'h0003);
        checkOutput("iss_reg_write", {31'h0, bus.ex_reg_write}, 32'd1);
        checkOutput("b2b_id_ready",  {31'h0, bus.id_ready},     32'd1);
        tick();
        applyStimulus(4'h2, 2'd0, 16'h0100, 2'd1, 16'h0200, 1'b0, 16'h0300, 2'd2, 1'b0, 1'b0);
        sbQueue.push_back('{a: 16'h0100, b: 16'h0300, op: 4'h2, rd: 2'd2});
        tick();
        idle();
        #1 checkOutput("b2b_last_valid", {31'h0, bus.ex_valid}, 32'd1);
        tick();
        #1 checkOutput("drain_valid", {31'h0, bus.ex_valid}, 32'd0);

        // rs2 bypass only applies when B comes from the register file
        bus.ex_ready = 1'b0;
        applyStimulus(4'h3, 2'd0, 16'h0001, 2'd3, 16'h7777, 1'b0, 16'h0042, 2'd0, 1'b1, 1'b0);
        sbQueue.push_back('{a: 16'h0001, b: 16'h0042, op: 4'h3, rd: 2'd0});
        tick();
        idle();
        setWb(1'b1, 1'b1, 2'd3, 16'h9999);
        #1 checkOutput("imm_b_no_fwd", {16'h0, bus.ex_b}, 32'h0042);
        bus.ex_ready = 1'b1;
        tick();
        setWb(1'b0, 1'b0, 2'd0, 16'h0);
        bus.ex_ready = 1'b0;
        applyStimulus(4'h4, 2'd0, 16'h0002, 2'd3, 16'h7777, 1'b1, 16'h0000, 2'd1, 1'b1, 1'b0);
        sbQueue.push_back('{a: 16'h0002, b: 16'h9999, op: 4'h4, rd: 2'd1});
        tick();
        idle();
        setWb(1'b1, 1'b1, 2'd3, 16'h9999);
        #1 checkOutput("rs2_wb_fwd", {16'h0, bus.ex_b}, 32'h9999);
        bus.ex_ready = 1'b1;
        tick();
        setWb(1'b0, 1'b0, 2'd0, 16'h0);

        // EX/MEM and WB both write rs1
        applyStimulus(4'h5, 2'd2, 16'h0000, 2'd0, 16'h0000, 1'b0, 16'h0011, 2'd2, 1'b1, 1'b0);
`ifdef ALU_ISSUE_FORWARD_EN
        sbQueue.push_back('{a: 16'hAAAA, b: 16'h0011, op: 4'h5, rd: 2'd2});
`else
        sbQueue.push_back('{a: 16'h5555, b: 16'h0011, op: 4'h5, rd: 2'd2});
`endif
        tick();
        idle();
        setExm(1'b1, 1'b1, 1'b0, 2'd2, 16'hAAAA);
        setWb(1'b1, 1'b1, 2'd2, 16'h5555);
        #1;
`ifdef ALU_ISSUE_FORWARD_EN
        checkOutput("prio_valid", {31'h0, bus.ex_valid}, 32'd1);
        checkOutput("prio_a",     {16'h0, bus.ex_a},     32'hAAAA);
`else
        checkOutput("prio_valid",     {31'h0, bus.ex_valid},     32'd0);
        checkOutput("prio_reg_write", {31'h0, bus.ex_reg_write}, 32'd0);
`endif
        tick();
        setExm(1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        #1;
`ifdef ALU_ISSUE_FORWARD_EN
        checkOutput("prio_after_valid", {31'h0, bus.ex_valid}, 32'd0);
`else
        checkOutput("prio_after_valid", {31'h0, bus.ex_valid}, 32'd1);
        checkOutput("prio_after_a",     {16'h0, bus.ex_a},     32'h5555);
`endif
        tick();
        setWb(1'b0, 1'b0, 2'd0, 16'h0);

        // Load-use on rs1 stalls one cycle, then WB supplies the loaded value
        applyStimulus(4'h6, 2'd2, 16'h0000, 2'd1, 16'h0022, 1'b1, 16'h0000, 2'd0, 1'b1, 1'b0);
        sbQueue.push_back('{a: 16'hBEEF, b: 16'h0022, op: 4'h6, rd: 2'd0});
        tick();
        idle();
        setExm(1'b1, 1'b1, 1'b1, 2'd2, 16'hDEAD);
        #1;
        checkOutput("lu_valid",     {31'h0, bus.ex_valid},     32'd0);
        checkOutput("lu_reg_write", {31'h0, bus.ex_reg_write}, 32'd0);
        tick();
        setExm(1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        setWb(1'b1, 1'b1, 2'd2, 16'hBEEF);
        #1;
        checkOutput("lu_after_valid", {31'h0, bus.ex_valid}, 32'd1);
        checkOutput("lu_after_a",     {16'h0, bus.ex_a},     32'hBEEF);
        tick();
        setWb(1'b0, 1'b0, 2'd0, 16'h0);

        // Held entry keeps forwarded value after producer retires
        bus.ex_ready = 1'b0;
        applyStimulus(4'h7, 2'd1, 16'h0000, 2'd0, 16'h0000, 1'b0, 16'h0007, 2'd3, 1'b1, 1'b0);
        sbQueue.push_back('{a: 16'h00FF, b: 16'h0007, op: 4'h7, rd: 2'd3});
        tick();
        idle();
        setExm(1'b1, 1'b1, 1'b0, 2'd1, 16'h00FF);
        #1;
`ifdef ALU_ISSUE_FORWARD_EN
        checkOutput("hold_c0_valid", {31'h0, bus.ex_valid}, 32'd1);
`else
        checkOutput("hold_c0_valid", {31'h0, bus.ex_valid}, 32'd0);
`endif
        tick();
        setExm(1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        setWb(1'b1, 1'b1, 2'd1, 16'h00FF);
        #1;
        checkOutput("hold_c1_valid", {31'h0, bus.ex_valid}, 32'd1);
        checkOutput("hold_c1_a",     {16'h0, bus.ex_a},     32'h00FF);
        tick();
        setWb(1'b0, 1'b1, 2'd1, 16'h1111);
        #1 checkOutput("hold_c2_a", {16'h0, bus.ex_a}, 32'h00FF);
        tick();
        bus.ex_ready = 1'b1;
        #1 checkOutput("hold_release_a", {16'h0, bus.ex_a}, 32'h00FF);
        tick();
        bus.ex_ready = 1'b0;
        setWb(1'b0, 1'b0, 2'd0, 16'h0);

        // Flush drops the held entry and refuses the concurrent decode
        applyStimulus(4'h8, 2'd0, 16'h0123, 2'd0, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);
        tick();
        applyStimulus(4'h9, 2'd1, 16'h0456, 2'd0, 16'h0000, 1'b0, 16'h0001, 2'd1, 1'b1, 1'b0);
        bus.flush = 1'b1;
        #1;
        checkOutput("fl_held_valid", {31'h0, bus.ex_valid}, 32'd1);
        checkOutput("fl_id_ready",   {31'h0, bus.id_ready}, 32'd0);
        tick();
        bus.flush = 1'b0;
        idle();
        bus.ex_ready = 1'b1;
        #1;
        checkOutput("fl_after_valid",    {31'h0, bus.ex_valid}, 32'd0);
        checkOutput("fl_after_id_ready", {31'h0, bus.id_ready}, 32'd1);
        tick(); tick();
        bus.ex_ready = 1'b0;

        // Reset while holding discards the entry immediately
        applyStimulus(4'h5, 2'd0, 16'h1234, 2'd0, 16'h0000, 1'b0, 16'h0000, 2'd1, 1'b1, 1'b0);
        tick();
        idle();
        #1 checkOutput("rh_held_a", {16'h0, bus.ex_a}, 32'h1234);
        reset = 1'b1;
        #1;
        checkOutput("rh_valid",    {31'h0, bus.ex_valid}, 32'd0);
        checkOutput("rh_op",       {28'h0, bus.ex_op},    32'd0);
        checkOutput("rh_id_ready", {31'h0, bus.id_ready}, 32'd1);
        checkOutput("rh_a",        {16'h0, bus.ex_a},     32'h0000);
        tick();
        reset = 1'b0;
        bus.ex_ready = 1'b1;
        tick(); tick();
        checkOutput("rh_post_valid", {31'h0, bus.ex_valid}, 32'd0);
        applyStimulus(4'hA, 2'd3, 16'h0BAD, 2'd0, 16'h0000, 1'b0, 16'h0001, 2'd2, 1'b0, 1'b1);
        sbQueue.push_back('{a: 16'h0BAD, b: 16'h0001, op: 4'hA, rd: 2'd2});
        tick();
        idle();
        #1 checkOutput("post_mem_read", {31'h0, bus.ex_mem_read}, 32'd1);
        tick(); tick();

        checkOutput("sb_drained",  sbQueue.size(), 32'd0);
        checkOutput("issue_count", issueCount,     32'd9);
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
